invol_arbiter: RTL and testbench

- Shares the single involuntary-response path to the host (the `param_data`/`param_write`/done response bus) between NUNITS units that raise `invol_req`, such as the stepper/endstop unit when a homing trigger occurs.
- Grants one requester at a time, in round-robin order.
- Muxes the granted unit's response stream onto the shared bus.
- Holds off the command dispatcher while a response is in flight, and aborts owners that stall.

---
 rtl/invol_arbiter_if.sv | 24 ++
 rtl/invol_arbiter.sv | 133 +++++++++++++
 tb/tb_invol_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/invol_arbiter_if.sv
// Unit-side and host-side signals of the involuntary-response bus shared by invol_arbiter.
// The arbiter takes the master modport; units and the host framer take the slave view.
interface invol_arbiter_if #(
    parameter int NUNITS = 4
);
    logic [NUNITS-1:0]    invol_req;
    logic [NUNITS-1:0]    invol_grant;
    logic [32*NUNITS-1:0] unit_param_data;
    logic [NUNITS-1:0]    unit_param_write;
    logic [NUNITS-1:0]    unit_done;
    logic [31:0]          param_data;
    logic                 param_write;
    logic                 rsp_done;

    modport master (
        input  invol_req, unit_param_data, unit_param_write, unit_done,
        output invol_grant, param_data, param_write, rsp_done
    );

    modport slave (
        output invol_req, unit_param_data, unit_param_write, unit_done,
        input  invol_grant, param_data, param_write, rsp_done
    );
endinterface

// File: rtl/invol_arbiter.sv
// Round-robin arbiter sharing the involuntary host-response path between NUNITS units.
// Define INVOL_ARB_FIXED_PRIO_EN for fixed priority selection (lowest index wins, no rr_ptr).
module invol_arbiter #(
    parameter int NUNITS  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    invol_arbiter_if.master      bus,
    input  logic                 cmd_busy,
    output logic                 hold_cmd,
    output logic                 timeout_err,
    output logic [3:0]           timeout_unit,
    input  logic                 clear_err
);
    localparam int IW = (NUNITS > 1) ? $clog2(NUNITS) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GRANT, ACTIVE} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   scan_base;
    logic            found;
    logic [CW-1:0]   cnt;
    logic [31:0]     own_data;
    logic            own_wr;
    logic            own_done;
    logic            abort;

`ifdef INVOL_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   next_ptr;

    assign scan_base = rr_ptr;
    assign next_ptr  = (int'(owner) == NUNITS - 1) ? '0 : owner + 1'b1;
`endif

    // First requester at or above scan_base, wrapping from NUNITS-1 back to 0.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUNITS; i++) begin
            if (!found && bus.invol_req[IW'((int'(scan_base) + i) % NUNITS)]) begin
                sel   = IW'((int'(scan_base) + i) % NUNITS);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        own_data = '0;
        own_wr   = 1'b0;
        own_done = 1'b0;
        for (int i = 0; i < NUNITS; i++) begin
            if (owner == IW'(i)) begin
                own_data = bus.unit_param_data[32*i +: 32];
                own_wr   = bus.unit_param_write[i];
                own_done = bus.unit_done[i];
            end
        end
    end

    // A done arriving on the last counted cycle still wins over the abort.
    assign abort = (state == ACTIVE) && !own_done && (cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            owner           <= '0;
            cnt             <= '0;
            hold_cmd        <= 1'b0;
            timeout_err     <= 1'b0;
            timeout_unit    <= '0;
            bus.invol_grant <= '0;
            bus.param_data  <= '0;
            bus.param_write <= 1'b0;
            bus.rsp_done    <= 1'b0;
`ifndef INVOL_ARB_FIXED_PRIO_EN
            rr_ptr          <= '0;
`endif
        end else begin
            bus.invol_grant <= '0;
            bus.param_write <= 1'b0;
            bus.rsp_done    <= 1'b0;
            if (clear_err)
                timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    hold_cmd <= 1'b0;
                    if (!cmd_busy && found) begin
                        bus.invol_grant <= NUNITS'(1) << sel;
                        hold_cmd        <= 1'b1;
                        owner           <= sel;
                        state           <= GRANT;
                    end
                end
                GRANT, ACTIVE: begin
                    if (abort) begin
                        timeout_err  <= 1'b1;
                        timeout_unit <= 4'(owner);
                        hold_cmd     <= 1'b0;
                        state        <= IDLE;
`ifndef INVOL_ARB_FIXED_PRIO_EN
                        rr_ptr       <= next_ptr;
`endif
                    end else begin
                        bus.param_write <= own_wr;
                        if (own_wr)
                            bus.param_data <= own_data;
                        if (own_done) begin
                            bus.rsp_done <= 1'b1;
                            state        <= IDLE;
`ifndef INVOL_ARB_FIXED_PRIO_EN
                            rr_ptr       <= next_ptr;
`endif
                        end else if (state == GRANT) begin
                            cnt   <= CW'(TIMEOUT - 1);
                            state <= ACTIVE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_invol_arbiter.sv
// Scoreboard bench for invol_arbiter: directed stimulus pushes expected grants/words/dones,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_invol_arbiter;
    localparam int NUNITS  = 4;
    localparam int TIMEOUT = 8;

    logic       clk;
    logic       rst;
    logic       cmd_busy;
    logic       hold_cmd;
    logic       timeout_err;
    logic [3:0] timeout_unit;
    logic       clear_err;

    int checks = 0;
    int errors = 0;

    logic [3:0]  exp_grant[$];
    logic [31:0] exp_word[$];
    logic [31:0] exp_done[$];

    invol_arbiter_if #(.NUNITS(NUNITS)) bus ();

    invol_arbiter #(
        .NUNITS (NUNITS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .cmd_busy    (cmd_busy),
        .hold_cmd    (hold_cmd),
        .timeout_err (timeout_err),
        .timeout_unit(timeout_unit),
        .clear_err   (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("[TB] FAIL %s: unexpected output %h with nothing expected at %0t", name, act, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] wr, input logic [3:0] dn,
                                 input int unit, input logic [31:0] word);
        bus.invol_req                      = req;
        bus.unit_param_write               = wr;
        bus.unit_done                      = dn;
        bus.unit_param_data[32*unit +: 32] = word;
    endtask

    task automatic waitGrant(output logic [3:0] g);
        g = '0;
        for (int n = 0; n < 40; n++) begin
            if (bus.invol_grant != '0) begin
                g = bus.invol_grant;
                return;
            end
            tick();
        end
        checkOutput("grant_wait_expired", 32'(bus.invol_grant), 32'hF);
    endtask

    // Scoreboard monitor: compares every presented grant, written word and done.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.invol_grant != '0) begin
                if (exp_grant.size() == 0) unexpected("grant", 32'(bus.invol_grant));
                else checkOutput("grant", 32'(bus.invol_grant), 32'(exp_grant.pop_front()));
            end
            if (bus.param_write) begin
                if (exp_word.size() == 0) unexpected("param_write", bus.param_data);
                else checkOutput("param_data", bus.param_data, exp_word.pop_front());
            end
            if (bus.rsp_done) begin
                if (exp_done.size() == 0) unexpected("rsp_done", bus.param_data);
                else checkOutput("rsp_done_word", bus.param_data, exp_done.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] g;
        int own;
        int exp_own;

        rst                 = 1'b1;
        cmd_busy            = 1'b0;
        clear_err           = 1'b0;
        bus.invol_req       = '0;
        bus.unit_param_data = '0;
        bus.unit_param_write= '0;
        bus.unit_done       = '0;
        #2;
        checkOutput("reset_grant", 32'(bus.invol_grant), 32'h0);
        checkOutput("reset_hold", 32'(hold_cmd), 32'h0);
        checkOutput("reset_pwrite", 32'(bus.param_write), 32'h0);
        checkOutput("reset_terr", 32'(timeout_err), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single request from unit 2, three words then done.
        $display("[TB] single request");
        exp_grant.push_back(4'b0100);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 2, 32'h0);
        tick();
        checkOutput("single_grant", 32'(bus.invol_grant), 32'h4);
        checkOutput("single_hold_on", 32'(hold_cmd), 32'h1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2, 32'h0);
        tick();
        checkOutput("single_grant_pulse", 32'(bus.invol_grant), 32'h0);
        exp_word.push_back(32'h2);
        applyStimulus(4'b0000, 4'b0100, 4'b0000, 2, 32'h2);
        tick();
        checkOutput("single_latency", {31'b0, bus.param_write} ^ bus.param_data, 32'h3);
        exp_word.push_back(32'h1);
        applyStimulus(4'b0000, 4'b0100, 4'b0000, 2, 32'h1);
        tick();
        exp_word.push_back(32'h0);
        exp_done.push_back(32'h0);
        applyStimulus(4'b0000, 4'b0100, 4'b0100, 2, 32'h0);
        tick();
        checkOutput("single_done", 32'(bus.rsp_done), 32'h1);
        checkOutput("single_hold_last", 32'(hold_cmd), 32'h1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2, 32'h0);
        tick();
        checkOutput("single_hold_off", 32'(hold_cmd), 32'h0);
        checkOutput("single_pwrite_off", 32'(bus.param_write), 32'h0);
        tick();

        // All four requesting continuously, each finishing in its grant cycle.
        $display("[TB] round robin");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
`ifdef INVOL_ARB_FIXED_PRIO_EN
            exp_grant.push_back(4'b0001);
`else
            exp_grant.push_back(4'b0001 << (k % 4));
`endif
        end
        applyStimulus(4'b1111, 4'b0000, 4'b0000, 0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            waitGrant(g);
            if (g == '0) break;
            own = 0;
            for (int b = 0; b < NUNITS; b++) if (g[b]) own = b;
`ifdef INVOL_ARB_FIXED_PRIO_EN
            exp_own = 0;
`else
            exp_own = k % 4;
`endif
            exp_word.push_back(32'h100 + 32'(exp_own));
            exp_done.push_back(32'h100 + 32'(exp_own));
            applyStimulus(4'b1111, g, g, own, 32'h100 + 32'(own));
            tick();
            applyStimulus((k == 4) ? 4'b0000 : 4'b1111, 4'b0000, 4'b0000, own, 32'h0);
        end
        tick();
        tick();

        // Command in progress beats a simultaneous request.
        $display("[TB] command tie");
        cmd_busy = 1'b1;
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("tie_no_grant", 32'(bus.invol_grant), 32'h0);
            checkOutput("tie_no_hold", 32'(hold_cmd), 32'h0);
        end
        cmd_busy = 1'b0;
        exp_grant.push_back(4'b0001);
        tick();
        checkOutput("tie_grant", 32'(bus.invol_grant), 32'h1);
        exp_word.push_back(32'h33);
        exp_done.push_back(32'h33);
        applyStimulus(4'b0000, 4'b0001, 4'b0001, 0, 32'h33);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 32'h0);
        tick();
        tick();

        // Unit 1 never finishes; unit 2 is waiting behind it.
        $display("[TB] timeout");
        exp_grant.push_back(4'b0010);
        applyStimulus(4'b0110, 4'b0000, 4'b0000, 1, 32'h0);
        tick();
        checkOutput("tmo_grant", 32'(bus.invol_grant), 32'h2);
        exp_grant.push_back(4'b0100);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 1, 32'h0);
        repeat (6) tick();
        checkOutput("tmo_not_yet", 32'(timeout_err), 32'h0);
        tick();
        checkOutput("tmo_last_cycle_err", 32'(timeout_err), 32'h0);
        checkOutput("tmo_last_cycle_hold", 32'(hold_cmd), 32'h1);
        clear_err = 1'b1;
        applyStimulus(4'b0100, 4'b0010, 4'b0000, 1, 32'h77);
        tick();
        clear_err = 1'b0;
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 1, 32'h0);
        checkOutput("tmo_err", 32'(timeout_err), 32'h1);
        checkOutput("tmo_unit", 32'(timeout_unit), 32'h1);
        checkOutput("tmo_hold", 32'(hold_cmd), 32'h0);
        checkOutput("tmo_pwrite", 32'(bus.param_write), 32'h0);
        tick();
        checkOutput("tmo_next_grant", 32'(bus.invol_grant), 32'h4);
        exp_word.push_back(32'h22);
        exp_done.push_back(32'h22);
        applyStimulus(4'b0000, 4'b0100, 4'b0100, 2, 32'h22);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2, 32'h0);
        checkOutput("tmo_sticky", 32'(timeout_err), 32'h1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checkOutput("tmo_clear", 32'(timeout_err), 32'h0);
        tick();

        // Non-owner strobes while unit 3 owns the bus.
        $display("[TB] foreign strobes");
        exp_grant.push_back(4'b1000);
        applyStimulus(4'b1000, 4'b0000, 4'b0000, 3, 32'h0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 3, 32'h0);
        tick();
        applyStimulus(4'b0000, 4'b0001, 4'b0001, 0, 32'hDEAD);
        tick();
        checkOutput("foreign_pwrite", 32'(bus.param_write), 32'h0);
        checkOutput("foreign_done", 32'(bus.rsp_done), 32'h0);
        checkOutput("foreign_hold_data", bus.param_data, 32'h22);
        exp_word.push_back(32'h3);
        exp_done.push_back(32'h3);
        applyStimulus(4'b0000, 4'b1000, 4'b1000, 3, 32'h3);
        bus.unit_param_write[0] = 1'b0;
        bus.unit_done[0]        = 1'b0;
        tick();
        checkOutput("owner_done", 32'(bus.rsp_done), 32'h1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 3, 32'h0);
        tick();
        tick();

        // Reset while unit 2 is mid-response.
        $display("[TB] reset mid-response");
        exp_grant.push_back(4'b0100);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 2, 32'h0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2, 32'h0);
        tick();
        exp_word.push_back(32'h5);
        applyStimulus(4'b0000, 4'b0100, 4'b0000, 2, 32'h5);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 2, 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_hold", 32'(hold_cmd), 32'h0);
        checkOutput("rst_pwrite", 32'(bus.param_write), 32'h0);
        checkOutput("rst_pdata", bus.param_data, 32'h0);
        checkOutput("rst_done", 32'(bus.rsp_done), 32'h0);
        tick();
        rst = 1'b0;
        exp_grant.push_back(4'b0001);
        applyStimulus(4'b0101, 4'b0000, 4'b0000, 0, 32'h0);
        tick();
        checkOutput("rst_first_grant", 32'(bus.invol_grant), 32'h1);
        exp_word.push_back(32'h66);
        exp_done.push_back(32'h66);
        applyStimulus(4'b0000, 4'b0001, 4'b0001, 0, 32'h66);
        tick();
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 0, 32'h0);
        tick();
        tick();

        checkOutput("grant_queue_empty", 32'(exp_grant.size()), 32'h0);
        checkOutput("word_queue_empty", 32'(exp_word.size()), 32'h0);
        checkOutput("done_queue_empty", 32'(exp_done.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
